// File: rtl/load_store_queue.sv
// load_store_queue
//   In-order load/store queue between issue and memory. Entries wait for
//   their base (Qj) and store-data (Qk) operands by snooping the CDB
//   channels and the queue's own load broadcast. The head entry goes to
//   memory when its operands are ready. Stores and IO loads must also be
//   committed by the ROB first. At most one memory access is in flight.
//
// Ports
//   clk, rst                     clock, synchronous active-high reset
//   i_rollback                   squash every uncommitted entry
//   o_full, o_count              occupancy
//   i_iss_*                      enqueue request (funct3 op, tag, operands)
//   i_cdb_valid/tag/data         NCDB snooped broadcast channels
//   i_commit_valid               ROB commits the oldest uncommitted store/IO load
//   o_out_valid/tag/data         load result broadcast
//   o_io_load_valid/tag          notice to ROB that an IO load is waiting
//   o_mem_*, i_mem_ready/rdata   single-outstanding memory port
//
// Optional feature: define LSQ_FWD_EN to enable forwarding from the last
// completed store to a matching non-IO load.
module load_store_queue #(
    parameter int DEPTH = 16,
    parameter int TAG_W = 4,
    parameter int NCDB  = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_rollback,
    output logic                   o_full,
    output logic [$clog2(DEPTH):0] o_count,
    input  logic                   i_iss_valid,
    input  logic                   i_iss_store,
    input  logic [2:0]             i_iss_op,
    input  logic [TAG_W-1:0]       i_iss_tag,
    input  logic [31:0]            i_iss_vj,
    input  logic [31:0]            i_iss_vk,
    input  logic [TAG_W-1:0]       i_iss_qj,
    input  logic [TAG_W-1:0]       i_iss_qk,
    input  logic [31:0]            i_iss_imm,
    input  logic [NCDB-1:0]        i_cdb_valid,
    input  logic [NCDB*TAG_W-1:0]  i_cdb_tag,
    input  logic [NCDB*32-1:0]     i_cdb_data,
    input  logic                   i_commit_valid,
    output logic                   o_out_valid,
    output logic [TAG_W-1:0]       o_out_tag,
    output logic [31:0]            o_out_data,
    output logic                   o_io_load_valid,
    output logic [TAG_W-1:0]       o_io_load_tag,
    output logic                   o_mem_req,
    output logic                   o_mem_we,
    output logic [31:0]            o_mem_addr,
    output logic [31:0]            o_mem_wdata,
    output logic [1:0]             o_mem_size,
    input  logic                   i_mem_ready,
    input  logic [31:0]            i_mem_rdata
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic {S_IDLE, S_WAIT} state_t;
    state_t r_state, w_state_nxt;

    // entry storage
    logic             r_st  [DEPTH];
    logic [2:0]       r_op  [DEPTH];
    logic [TAG_W-1:0] r_tag [DEPTH];
    logic [31:0]      r_vj  [DEPTH];
    logic [31:0]      r_vk  [DEPTH];
    logic [TAG_W-1:0] r_qj  [DEPTH];
    logic [TAG_W-1:0] r_qk  [DEPTH];
    logic [31:0]      r_imm [DEPTH];

    logic [PW-1:0] r_head, r_tail;
    logic [CW-1:0] r_count, r_ccnt, w_ccnt_nxt;

    // in-flight access bookkeeping
    logic             r_inf_st, r_inf_comm, r_inf_kill;
    logic [2:0]       r_inf_op;
    logic [TAG_W-1:0] r_inf_tag;
    logic             r_io_sent;

    logic                   w_h_st, w_h_io, w_h_comm, w_h_rdy, w_nempty;
    logic [31:0]            w_h_addr;
    logic                   w_enq, w_pop, w_issue, w_fwd, w_fwd_hit, w_commit;
    logic                   w_io_cond, w_kill;
    logic [TAG_W+31:0]      w_iss_j, w_iss_k;

    // Resolve one operand against the CDB channels (lowest index first),
    // then against our own load broadcast.
    function automatic logic [TAG_W+31:0] f_snoop(input logic [TAG_W-1:0] q,
                                                  input logic [31:0] v);
        logic [TAG_W+31:0] r;
        logic              hit;
        r   = {q, v};
        hit = 1'b0;
        for (int i = 0; i < NCDB; i++) begin
            if (!hit && q != '0 && i_cdb_valid[i] && i_cdb_tag[i*TAG_W +: TAG_W] == q) begin
                r   = {{TAG_W{1'b0}}, i_cdb_data[i*32 +: 32]};
                hit = 1'b1;
            end
        end
        if (!hit && q != '0 && o_out_valid && o_out_tag == q)
            r = {{TAG_W{1'b0}}, o_out_data};
        return r;
    endfunction

    function automatic logic [31:0] f_ext(input logic [2:0] op, input logic [31:0] d);
        case (op)
            3'b000:  return {{24{d[7]}}, d[7:0]};
            3'b001:  return {{16{d[15]}}, d[15:0]};
            3'b100:  return {24'b0, d[7:0]};
            3'b101:  return {16'b0, d[15:0]};
            default: return d;
        endcase
    endfunction

    assign w_iss_j  = f_snoop(i_iss_qj, i_iss_vj);
    assign w_iss_k  = f_snoop(i_iss_qk, i_iss_vk);

    assign o_full   = (r_count == CW'(DEPTH));
    assign o_count  = r_count;
    assign w_nempty = (r_count != '0);
    assign w_h_st   = r_st[r_head];
    assign w_h_addr = r_vj[r_head] + r_imm[r_head];
    assign w_h_io   = (w_h_addr[17:16] == 2'b11);
    // committed entries are always the oldest, so the head is committed
    // whenever any entry is
    assign w_h_comm = (r_ccnt != '0);
    assign w_h_rdy  = w_nempty && r_qj[r_head] == '0 &&
                      (w_h_st ? (r_qk[r_head] == '0 && w_h_comm) : (!w_h_io || w_h_comm));

    assign w_enq    = i_iss_valid && !o_full && !i_rollback;
    assign w_pop    = w_issue || w_fwd;
    assign w_commit = i_commit_valid && (r_ccnt < r_count);
    assign w_ccnt_nxt = r_ccnt + CW'(w_commit) - CW'(w_pop && w_h_comm);
    assign w_io_cond = w_nempty && !w_h_st && w_h_io && r_qj[r_head] == '0 &&
                       !w_h_comm && !i_rollback;
    // an uncommitted load squashed while in flight must not broadcast
    assign w_kill   = r_inf_kill || (i_rollback && !r_inf_comm);

`ifdef LSQ_FWD_EN
    logic        r_fwd_vld;
    logic [31:0] r_fwd_addr, r_fwd_data;
    logic [1:0]  r_fwd_size;
    // forwarding is only attempted from IDLE, so no store can be in WAIT
    assign w_fwd_hit = r_fwd_vld && !w_h_st && !w_h_io &&
                       r_fwd_addr == w_h_addr && r_fwd_size == r_op[r_head][1:0];
`else
    assign w_fwd_hit = 1'b0;
`endif

    // issue decisions are held off during rollback so nothing that is
    // being squashed can leave the queue
    always_comb begin
        w_state_nxt = r_state;
        w_issue     = 1'b0;
        w_fwd       = 1'b0;
        case (r_state)
            S_IDLE: if (w_h_rdy && !i_rollback) begin
                if (w_fwd_hit) begin
                    w_fwd = 1'b1;
                end else begin
                    w_issue     = 1'b1;
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: if (i_mem_ready) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_qj[i] <= '0;
                r_qk[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                {r_qj[i], r_vj[i]} <= f_snoop(r_qj[i], r_vj[i]);
                {r_qk[i], r_vk[i]} <= f_snoop(r_qk[i], r_vk[i]);
            end
            if (w_enq) begin
                r_st[r_tail]  <= i_iss_store;
                r_op[r_tail]  <= i_iss_op;
                r_tag[r_tail] <= i_iss_tag;
                r_imm[r_tail] <= i_iss_imm;
                {r_qj[r_tail], r_vj[r_tail]} <= w_iss_j;
                {r_qk[r_tail], r_vk[r_tail]} <= w_iss_k;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_head <= '0; r_tail <= '0; r_count <= '0; r_ccnt <= '0;
            r_inf_st <= 1'b0; r_inf_comm <= 1'b0; r_inf_kill <= 1'b0;
            r_inf_op <= '0; r_inf_tag <= '0; r_io_sent <= 1'b0;
            o_out_valid <= 1'b0; o_out_tag <= '0; o_out_data <= '0;
            o_io_load_valid <= 1'b0; o_io_load_tag <= '0;
            o_mem_req <= 1'b0; o_mem_we <= 1'b0; o_mem_addr <= '0;
            o_mem_wdata <= '0; o_mem_size <= '0;
`ifdef LSQ_FWD_EN
            r_fwd_vld <= 1'b0; r_fwd_addr <= '0; r_fwd_data <= '0; r_fwd_size <= '0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_ccnt  <= w_ccnt_nxt;
            if (i_rollback) begin
                r_tail  <= r_head + w_ccnt_nxt[PW-1:0];
                r_count <= w_ccnt_nxt;
            end else begin
                r_tail  <= r_tail + PW'(w_enq);
                r_head  <= r_head + PW'(w_pop);
                r_count <= r_count + CW'(w_enq) - CW'(w_pop);
            end

            o_mem_req <= w_issue;
            if (w_issue) begin
                o_mem_we    <= w_h_st;
                o_mem_addr  <= w_h_addr;
                o_mem_size  <= r_op[r_head][1:0];
                o_mem_wdata <= r_vk[r_head];
                r_inf_st    <= w_h_st;
                r_inf_op    <= r_op[r_head];
                r_inf_tag   <= r_tag[r_head];
                r_inf_comm  <= w_h_comm;
                r_inf_kill  <= 1'b0;
            end else if (r_state == S_WAIT && i_rollback && !r_inf_comm) begin
                r_inf_kill  <= 1'b1;
            end

            o_out_valid <= 1'b0;
            if (r_state == S_WAIT && i_mem_ready) begin
                if (!r_inf_st && !w_kill) begin
                    o_out_valid <= 1'b1;
                    o_out_tag   <= r_inf_tag;
                    o_out_data  <= f_ext(r_inf_op, i_mem_rdata);
                end
`ifdef LSQ_FWD_EN
                if (r_inf_st) begin
                    r_fwd_vld  <= 1'b1;
                    r_fwd_addr <= o_mem_addr;
                    r_fwd_size <= o_mem_size;
                    r_fwd_data <= o_mem_wdata;
                end
`endif
            end
`ifdef LSQ_FWD_EN
            if (w_fwd) begin
                o_out_valid <= 1'b1;
                o_out_tag   <= r_tag[r_head];
                o_out_data  <= f_ext(r_op[r_head], r_fwd_data);
            end
`endif

            // one notice per IO-load head; re-armed when the head changes
            o_io_load_valid <= w_io_cond && !r_io_sent;
            if (w_io_cond && !r_io_sent) o_io_load_tag <= r_tag[r_head];
            r_io_sent <= (w_pop || i_rollback) ? 1'b0 : (r_io_sent || w_io_cond);
        end
    end
endmodule

// File: doc/load_store_queue.md
LOAD_STORE_QUEUE -- requirements
Module: load_store_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 16, queue entries (power of two, >=2).
REQ-002 SHALL have parameter TAG_W, default 4, ROB tag width; tag 0 = null/ready.
REQ-003 SHALL have parameter NCDB, default 2, number of snooped broadcast channels.
REQ-004 SHALL have port clk  in  1  clock; rst  in  1  reset (synchronous, active-high).
REQ-005 SHALL have port rollback  in  1  squash all uncommitted entries.
REQ-006 SHALL have port full  out  1  and count  out  $clog2(DEPTH)+1  occupancy.
REQ-007 SHALL have issue ports: iss_valid in 1; iss_store in 1; iss_op in 3 (funct3); iss_tag in TAG_W; iss_vj/iss_vk in 32; iss_qj/iss_qk in TAG_W; iss_imm in 32.
REQ-008 SHALL have cdb_valid in NCDB, cdb_tag in NCDB*TAG_W, cdb_data in NCDB*32 (channel i at slice i).
REQ-009 SHALL have commit_valid in 1 (ROB commits oldest uncommitted store or IO load).
REQ-010 SHALL have out_valid out 1, out_tag out TAG_W, out_data out 32 (load result broadcast).
REQ-011 SHALL have io_load_valid out 1, io_load_tag out TAG_W (IO-load notice to ROB).
REQ-012 SHALL have mem_req out 1, mem_we out 1, mem_addr out 32, mem_wdata out 32, mem_size out 2 (0 byte, 1 half, 2 word), mem_ready in 1, mem_rdata in 32.

Function
REQ-013 SHALL enqueue at tail when iss_valid && !full; iss_valid while full is ignored; full = (count==DEPTH).
REQ-014 SHALL capture same-cycle CDB matches for iss_qj/iss_qk at enqueue; lowest channel index wins on duplicate tags.
REQ-015 SHALL, every cycle, replace Qj/Qk==cdb_tag[i] (nonzero) with cdb_data[i] in all valid entries; also from own out_valid result.
REQ-016 SHALL compute address = Vj + imm modulo 2^32; IO region is address[17:16]==2'b11.
REQ-017 SHALL keep committed_cnt; commit_valid marks entry (head + committed_cnt) committed and increments it.
REQ-018 SHALL treat head ready when: non-IO load Qj==0; IO load Qj==0 and committed; store Qj==Qk==0 and committed.
REQ-019 SHALL use FSM IDLE->WAIT: in IDLE with non-empty queue and ready head, pulse mem_req one cycle with address/size/Vk/we, pop head, go WAIT; committed head decrements committed_cnt.
REQ-020 SHALL in WAIT hold until mem_ready, then return to IDLE; next request no earlier than the cycle after mem_ready.
REQ-021 SHALL on load completion pulse out_valid one cycle after mem_ready with out_tag and data sign/zero-extended per funct3 (LB, LH, LW, LBU, LHU); stores produce no broadcast.
REQ-022 SHALL pulse io_load_valid once per IO-load head whose Qj==0 and not yet committed.
REQ-023 SHALL on rollback set tail = head + committed_cnt, drop enqueue that cycle, still apply same-cycle commit_valid.
REQ-024 SHALL on rollback during an uncommitted load in WAIT complete the memory handshake but suppress out_valid; committed in-flight accesses complete normally.
REQ-025 SHALL wrap head/tail modulo DEPTH; count stays exact under simultaneous enqueue and pop.

Reset
REQ-026 SHALL on rst clear head, tail, count, committed_cnt, all Q fields, state=IDLE, and drive full, out_valid, io_load_valid, mem_req, mem_we to 0 and all data/address/tag outputs to 0.
REQ-027 SHALL abandon an in-flight access on rst; a mem_ready after reset is ignored.

Configuration
REQ-028 SHALL with LSQ_FWD_EN defined keep last completed store address/size/data; a ready non-IO head load with identical address and size, and no store in WAIT, completes without mem_req, out_valid the next cycle with extended forwarded data.
REQ-029 SHALL without LSQ_FWD_EN send every load to memory; no forwarding logic present.

Verification
REQ-030 SHALL test: enqueue LW vj=0x100 imm=4 tags ready -> mem_req addr 0x104 size 2; mem_rdata 0xDEADBEEF -> out_valid with 0xDEADBEEF.
REQ-031 SHALL test: LB from 0x80, mem_rdata 0x000000F0 -> out_data 0xFFFFFFF0; LBU -> 0x000000F0.
REQ-032 SHALL test: SW qk=3, cdb tag 3 data 0x55, commit_valid -> mem_req we=1 wdata 0x55; no mem_req before commit.
REQ-033 SHALL test: LW addr 0x30000 -> single io_load_valid pulse; mem_req only after commit_valid.
REQ-034 SHALL test: DEPTH entries enqueued -> full=1, extra iss_valid ignored; rollback with committed_cnt=1 -> count=1.
REQ-035 SHALL test with LSQ_FWD_EN: SW 0x12345678 to 0x200 then LW 0x200 -> out_valid 0x12345678, no load mem_req.
